pio_edge_irq: RTL and testbench

Parametrised Avalon-MM input PIO with synchroniser, per-bit debounce filter, configurable edge capture and maskable interrupt. It replaces the single-bit level-only interrupt inputs on the peripheral bus, such as the USB controller nINT line, and serves buttons and other multi-bit external status lines. Register map, read latency and write semantics match the existing PIO slaves, so software drivers extend unchanged.

---
 rtl/pio_edge_irq.sv | 157 +++++++++++++++
 tb/tb_pio_edge_irq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_edge_irq.sv
// pio_edge_irq: Avalon-MM input PIO with a per-bit synchroniser, debounce filter,
// edge capture and maskable interrupt. The register map matches the existing PIO slaves.
module pio_edge_irq #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ADDR_DATA = 2'd0;
  localparam logic [1:0]       ADDR_MASK = 2'd2;
  localparam logic [1:0]       ADDR_EDGE = 2'd3;

  logic             wr_en;
  logic             unused_wdata;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] ec_q;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sync_d[i] = (i == 0) ? in_port : sync_q[(i == 0) ? 0 : i - 1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A new value must hold for DEBOUNCE_CYCLES sampled cycles; any return to f restarts the count.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_d[b] = cnt_q[b];
      if (sync_s[b] == filt_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        filt_d[b] = sync_s[b];
        cnt_d[b]  = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = filt_q;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = ec_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int b = 0; b < WIDTH; b++) begin
        cnt_q[b] <= '0;
      end
      filt_q     <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int b = 0; b < WIDTH; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      filt_q     <= filt_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  generate
    if (EDGE_TYPE != 0) begin : g_edge
      logic [WIDTH-1:0] filt_dly_q;
      logic [WIDTH-1:0] filt_dly_d;
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
      logic [WIDTH-1:0] ev;
      logic [WIDTH-1:0] ec_clr;
      logic [WIDTH-1:0] ec_d;

      // A new event on the same edge as a write-1-to-clear keeps the bit set.
      always_comb begin
        filt_dly_d = filt_q;
        rise       = filt_q & ~filt_dly_q;
        fall       = ~filt_q & filt_dly_q;
        case (EDGE_TYPE)
          1:       ev = rise;
          2:       ev = fall;
          default: ev = rise | fall;
        endcase
        ec_clr = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
        ec_d   = (ec_q & ~ec_clr) | ev;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          filt_dly_q <= '0;
          ec_q       <= '0;
        end else begin
          filt_dly_q <= filt_dly_d;
          ec_q       <= ec_d;
        end
      end
    end else begin : g_level
      assign ec_q = '0;
    end
  endgenerate

  always_comb begin
    if (EDGE_TYPE == 0) begin
      irq = |(filt_q & mask_q);
    end else begin
      irq = |(ec_q & mask_q);
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_pio_edge_irq.sv
// Scoreboard bench for pio_edge_irq: stimulus pushes expected readdata/irq values
// tagged with the cycle they are due; a monitor pops and compares on falling edges.
module tb_pio_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in4;
  logic [31:0] in32;

  logic [31:0] rd0, rd1, rd2, rd3, rd4;
  logic        irq0, irq1, irq2, irq3, irq4;
  logic [31:0] rd_v [5];
  logic        irq_v [5];

  always #5 clk = ~clk;

  pio_edge_irq #(.WIDTH(4), .EDGE_TYPE(1)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in4), .readdata(rd0), .irq(irq0));
  pio_edge_irq #(.WIDTH(4), .EDGE_TYPE(2)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in4), .readdata(rd1), .irq(irq1));
  pio_edge_irq #(.WIDTH(4), .EDGE_TYPE(3)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in4), .readdata(rd2), .irq(irq2));
  pio_edge_irq #(.WIDTH(4), .EDGE_TYPE(0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in4), .readdata(rd3), .irq(irq3));
  pio_edge_irq #(.WIDTH(32), .EDGE_TYPE(1)) u_wide (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in32), .readdata(rd4), .irq(irq4));

  always_comb begin
    rd_v[0] = rd0;  rd_v[1] = rd1;  rd_v[2] = rd2;  rd_v[3] = rd3;  rd_v[4] = rd4;
    irq_v[0] = irq0; irq_v[1] = irq1; irq_v[2] = irq2; irq_v[3] = irq3; irq_v[4] = irq4;
  end

  typedef struct {
    int          due;
    int          dut;
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int dut, input bit is_irq, input logic [31:0] exp,
                      input string name, input int due);
    item_t it;
    it.due = due; it.dut = dut; it.is_irq = is_irq; it.exp = exp; it.name = name;
    sb.push_back(it);
  endtask

  // Expectations for the state seen after the next rising edge.
  task automatic exp_rd(input int dut, input logic [31:0] exp, input string name);
    push(dut, 1'b0, exp, name, cyc + 1);
  endtask

  task automatic exp_irq(input int dut, input logic exp, input string name);
    push(dut, 1'b1, {31'b0, exp}, name, cyc + 1);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input logic [1:0] a);
    address = a;
  endtask

  task automatic wr_start(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
  endtask

  task automatic wr_end();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin : monitor
    item_t       it;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        it  = sb.pop_front();
        act = it.is_irq ? {31'b0, irq_v[it.dut]} : rd_v[it.dut];
        checks++;
        if (it.due != cyc || act !== it.exp) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h (due cycle %0d, checked %0d)",
                   it.name, it.dut, act, it.exp, it.due, cyc);
        end
      end
    end
  end

  initial begin : stim
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in4 = '0; in32 = '0;
    tick(3);
    checks++;
    if (rd0 !== 32'h0) begin
      errors++; $display("FAIL in_rst_rd0: got %h", rd0);
    end
    checks++;
    if (rd4 !== 32'h0) begin
      errors++; $display("FAIL in_rst_rd4: got %h", rd4);
    end
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL in_rst_irq0: got %b", irq0);
    end
    checks++;
    if (irq3 !== 1'b0) begin
      errors++; $display("FAIL in_rst_irq3: got %b", irq3);
    end
    reset_n = 1'b1;
    tick(2);

    // Reset state
    set_addr(0);
    for (int d = 0; d < 5; d++) exp_rd(d, 32'h0, "rst_data");
    exp_irq(0, 1'b0, "rst_irq");
    tick();
    set_addr(2); exp_rd(0, 32'h0, "rst_mask"); tick();
    set_addr(3); exp_rd(4, 32'h0, "rst_ec");   tick();

    // Three-cycle glitch on bit 2 must not pass the filter
    in4 = 4'h4; tick(3);
    in4 = 4'h0; tick(6);
    set_addr(0); exp_rd(0, 32'h0, "glitch_data"); tick();
    set_addr(3); exp_rd(0, 32'h0, "glitch_ec"); exp_rd(2, 32'h0, "glitch_ec_any"); tick();

    // Held step: f at edge 5 (DATA read shows it one edge later), ec at edge 6
    in4 = 4'h4; set_addr(0);
    for (int e = 0; e < 8; e++) begin
      if (e == 4) exp_rd(0, 32'h0, "deb_data_edge4");
      if (e == 6) begin
        exp_rd(0, 32'h4, "deb_data_edge6");
        exp_rd(3, 32'h4, "deb_lvl_data");
      end
      if (e == 7) exp_irq(0, 1'b0, "gate_mask0");
      tick();
    end
    set_addr(3);
    exp_rd(0, 32'h4, "ec_rise"); exp_rd(1, 32'h0, "ec_fall_none");
    exp_rd(2, 32'h4, "ec_any_rise"); exp_rd(3, 32'h0, "ec_lvl_zero");
    tick();

    // Mask gating and write-1-to-clear
    wr_start(2, 32'hFFFF_FFF4);
    exp_irq(0, 1'b1, "gate_mask_on"); exp_irq(3, 1'b1, "lvl_irq_on");
    exp_irq(1, 1'b0, "gate_fall_ec0");
    tick(); wr_end();
    set_addr(2);
    exp_rd(0, 32'h4, "mask_rd_trunc"); exp_rd(4, 32'hFFFF_FFF4, "mask_rd_wide");
    tick();
    wr_start(3, 32'h4);
    exp_irq(0, 1'b0, "clr_irq"); exp_irq(2, 1'b0, "clr_irq_any");
    tick(); wr_end();
    set_addr(3); exp_rd(0, 32'h0, "clr_ec"); tick();

    // Falling step: fall/any capture at edge 6, level irq follows f at edge 5
    in4 = 4'h0;
    for (int e = 0; e < 8; e++) begin
      if (e == 4) exp_irq(3, 1'b1, "lvl_irq_pre");
      if (e == 5) begin
        exp_irq(1, 1'b0, "fall_irq_edge5");
        exp_irq(3, 1'b0, "lvl_irq_follow");
      end
      if (e == 6) begin
        exp_irq(1, 1'b1, "fall_irq_edge6");
        exp_irq(2, 1'b1, "any_irq_fall");
      end
      if (e == 7) exp_irq(0, 1'b0, "rise_ignores_fall");
      tick();
    end

    // Rising step: exact irq timing on the rising-edge instance
    in4 = 4'h4;
    for (int e = 0; e < 8; e++) begin
      if (e == 5) exp_irq(0, 1'b0, "rise_irq_edge5");
      if (e == 6) exp_irq(0, 1'b1, "rise_irq_edge6");
      tick();
    end
    set_addr(3);
    exp_rd(1, 32'h4, "ec_fall"); exp_rd(2, 32'h4, "ec_any_both");
    tick();
    wr_start(3, 32'hF); exp_irq(1, 1'b0, "clr_all"); tick(); wr_end();

    // Set beats a simultaneous clear of the same bit
    wr_start(2, 32'h5); tick(); wr_end();
    in4 = 4'h5;
    for (int e = 0; e < 8; e++) begin
      if (e == 5) exp_irq(0, 1'b0, "sbc_irq_edge5");
      if (e == 6) begin
        wr_start(3, 32'h1);
        exp_irq(0, 1'b1, "sbc_irq_edge6");
      end
      if (e == 7) begin
        wr_end(); set_addr(3);
        exp_irq(0, 1'b1, "sbc_irq_hold");
        exp_rd(0, 32'h1, "sbc_ec_bit0");
      end
      tick();
    end
    wr_start(3, 32'h1); exp_irq(0, 1'b0, "sbc_clear_later"); tick(); wr_end();

    // Level mode: irq follows DATA bit 0 under mask 0x1, EDGECAPTURE reads 0
    wr_start(2, 32'h1); exp_irq(3, 1'b1, "lvl_mask1"); tick(); wr_end();
    in4 = 4'h4;
    for (int e = 0; e < 7; e++) begin
      if (e == 4) exp_irq(3, 1'b1, "lvl_irq_hold");
      if (e == 5) exp_irq(3, 1'b0, "lvl_irq_drop");
      tick();
    end
    set_addr(3); exp_rd(3, 32'h0, "lvl_ec_read0"); tick();
    wr_start(0, 32'hF); tick(); wr_end();
    set_addr(0); exp_rd(0, 32'h4, "data_ro"); tick();
    set_addr(1); exp_rd(0, 32'h0, "reserved"); tick();

    // Walking one across the 32-bit instance
    for (int i = 0; i < 32; i++) begin
      in32 = 32'h1 << i;
      tick(8);
      set_addr(3); exp_rd(4, 32'h1 << i, $sformatf("walk_ec%0d", i)); tick();
      set_addr(0); exp_rd(4, 32'h1 << i, $sformatf("walk_data%0d", i)); tick();
      wr_start(3, 32'h1 << i); tick(); wr_end();
    end

    // Asynchronous reset mid-operation
    wr_start(2, 32'h6); tick(); wr_end();
    in4 = 4'h6; tick(8);
    set_addr(3);
    exp_rd(0, 32'h2, "pre_rst_ec"); exp_irq(0, 1'b1, "pre_rst_irq");
    exp_irq(3, 1'b1, "pre_rst_lvl_irq");
    tick();
    in4 = 4'hF; tick(3);
    @(posedge clk); #2;
    reset_n = 1'b0;
    push(0, 1'b0, 32'h0, "rst_async_rd", cyc);
    push(0, 1'b1, 32'h0, "rst_async_irq", cyc);
    push(3, 1'b1, 32'h0, "rst_async_lvl_irq", cyc);
    #1;
    checks++;
    if (rd0 !== 32'h0) begin
      errors++; $display("FAIL rst_now_rd0: got %h", rd0);
    end
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL rst_now_irq0: got %b", irq0);
    end
    checks++;
    if (irq3 !== 1'b0) begin
      errors++; $display("FAIL rst_now_irq3: got %b", irq3);
    end
    in4 = 4'h0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    set_addr(2);
    exp_rd(0, 32'h0, "post_rst_mask"); exp_rd(4, 32'h0, "post_rst_mask_w");
    tick();
    set_addr(0); exp_rd(0, 32'h0, "post_rst_data"); tick();
    tick(6);
    set_addr(3);
    exp_rd(0, 32'h0, "post_rst_ec");
    exp_rd(4, 32'h8000_0000, "held_high_edge");
    tick();

    for (int k = 0; k < 5 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s dut%0d: never checked, expected %h", it.name, it.dut, it.exp);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
